// File: rtl/stepper_pkg.sv
// Shared definitions for the step/dir motion sequencer: FSM state encoding
// and default timing constants for a 50 MHz clock.
package stepper_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        PULSE_HI = 3'd2,
        PULSE_LO = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int DEF_START_PER = 250000;  // 200 Hz start/stop rate
    localparam int DEF_ACCEL     = 1000;
    localparam int DEF_PULSE_CYC = 250;     // 5 us step pulse
    localparam int DEF_DIR_SETUP = 100;     // 2 us dir/enable setup

endpackage

// File: rtl/stepper_ramp_gen.sv
// Trapezoidal ramp state: current step period and ramp depth, updated once
// per step on a strobe using the number of steps still to be issued.
module stepper_ramp_gen
    import stepper_pkg::*;
#(
    parameter int STEP_W    = 16,
    parameter int PER_W     = 20,
    parameter int START_PER = DEF_START_PER,
    parameter int ACCEL     = DEF_ACCEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [STEP_W-1:0] remaining_i,
    input  logic [PER_W-1:0]  min_eff_i,
    output logic [PER_W-1:0]  cur_per_o
);

    localparam logic [PER_W:0] START_W = (PER_W+1)'(START_PER);
    localparam logic [PER_W:0] ACCEL_W = (PER_W+1)'(ACCEL);

    logic [PER_W-1:0]  cur_per_q,  cur_per_d;
    logic [STEP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [PER_W:0]    per_up;
    logic [PER_W:0]    per_floor;

    // One extra bit so neither sum can wrap before the comparison.
    assign per_up    = {1'b0, cur_per_q} + ACCEL_W;
    assign per_floor = {1'b0, min_eff_i} + ACCEL_W;

    always_comb begin
        cur_per_d  = cur_per_q;
        ramp_cnt_d = ramp_cnt_q;
        if ((remaining_i <= ramp_cnt_q) && (ramp_cnt_q != '0)) begin
            cur_per_d  = (per_up > START_W) ? START_W[PER_W-1:0] : per_up[PER_W-1:0];
            ramp_cnt_d = ramp_cnt_q - STEP_W'(1);
        end else if ((remaining_i > ramp_cnt_q) && ({1'b0, cur_per_q} >= per_floor)) begin
            cur_per_d  = cur_per_q - ACCEL_W[PER_W-1:0];
            ramp_cnt_d = ramp_cnt_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_per_q  <= '0;
            ramp_cnt_q <= '0;
        end else if (load_i) begin
            cur_per_q  <= START_W[PER_W-1:0];
            ramp_cnt_q <= '0;
        end else if (step_i) begin
            cur_per_q  <= cur_per_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign cur_per_o = cur_per_q;

endmodule

// File: rtl/stepper_move_ctrl.sv
// Counted, ramped, abortable stepper move sequencer driving step/dir/enable
// with direction setup time and fixed step pulse width.
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int STEP_W    = 16,
    parameter int PER_W     = 20,
    parameter int START_PER = DEF_START_PER,
    parameter int ACCEL     = DEF_ACCEL,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int DIR_SETUP = DEF_DIR_SETUP,
    parameter bit HOLD_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]  cmd_min_per,
    input  logic              abort,
    output logic              motor_en,
    output logic              motor_dir,
    output logic              motor_step,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    localparam logic [PER_W-1:0] PER_LO   = PER_W'(2 * PULSE_CYC);
    localparam logic [PER_W-1:0] PER_HI   = PER_W'(START_PER);
    localparam logic [PER_W-1:0] SETUP_LD = PER_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] HI_LD    = PER_W'(PULSE_CYC - 1);
    localparam logic [PER_W-1:0] LO_OFS   = PER_W'(PULSE_CYC + 1);

    state_t            state_q;
    logic [PER_W-1:0]  cnt_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] steps_done_q;
    logic [PER_W-1:0]  min_eff_q, min_eff_d;
    logic              abort_q;
    logic              cmd_ready_q, busy_q, done_q;
    logic              motor_en_q, motor_dir_q, motor_step_q;

    logic              accept;
    logic              enter_hi;
    logic              ramp_step;
    logic [STEP_W-1:0] remaining_after;
    logic [PER_W-1:0]  cur_per;

    always_comb begin
        min_eff_d = cmd_min_per;
        if (cmd_min_per < PER_LO) begin
            min_eff_d = PER_LO;
        end else if (cmd_min_per > PER_HI) begin
            min_eff_d = PER_HI;
        end
    end

    assign accept = (state_q == IDLE) && cmd_valid;

    // The ramp is stepped as each pulse starts, so by the end of the high
    // phase cur_per already holds the period for the coming interval.
    assign enter_hi        = ((state_q == SETUP) || (state_q == PULSE_LO)) && !abort && (cnt_q == '0);
    assign remaining_after = steps_q - steps_done_q - STEP_W'(1);
    assign ramp_step       = enter_hi && (remaining_after != '0);

    stepper_ramp_gen #(
        .STEP_W    (STEP_W),
        .PER_W     (PER_W),
        .START_PER (START_PER),
        .ACCEL     (ACCEL)
    ) u_ramp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .step_i      (ramp_step),
        .remaining_i (remaining_after),
        .min_eff_i   (min_eff_q),
        .cur_per_o   (cur_per)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            steps_q      <= '0;
            steps_done_q <= '0;
            min_eff_q    <= '0;
            abort_q      <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            motor_en_q   <= 1'b0;
            motor_dir_q  <= 1'b0;
            motor_step_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        steps_q      <= cmd_steps;
                        min_eff_q    <= min_eff_d;
                        steps_done_q <= '0;
                        abort_q      <= 1'b0;
                        cmd_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        if (cmd_steps == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= SETUP;
                            motor_dir_q <= cmd_dir;
                            motor_en_q  <= 1'b1;
                            cnt_q       <= SETUP_LD;
                        end
                    end
                end
                SETUP, PULSE_LO: begin
                    if (abort) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q      <= PULSE_HI;
                        motor_step_q <= 1'b1;
                        steps_done_q <= steps_done_q + STEP_W'(1);
                        cnt_q        <= HI_LD;
                    end else begin
                        cnt_q <= cnt_q - PER_W'(1);
                    end
                end
                PULSE_HI: begin
                    // An abort here is remembered so the pulse keeps full width.
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        motor_step_q <= 1'b0;
                        if ((steps_done_q == steps_q) || abort || abort_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PULSE_LO;
                            cnt_q   <= cur_per - LO_OFS;
                        end
                    end else begin
                        cnt_q <= cnt_q - PER_W'(1);
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    motor_en_q  <= motor_en_q & HOLD_EN;
                end
                default: begin
                    state_q      <= IDLE;
                    cmd_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    motor_step_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign motor_en   = motor_en_q;
    assign motor_dir  = motor_dir_q;
    assign motor_step = motor_step_q;
    assign steps_done = steps_done_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl with shortened timing constants:
// table of whole moves plus hand-written abort and reset sequences.
module tb_stepper_move_ctrl;

    localparam int STEP_W = 16;
    localparam int PER_W  = 20;
    localparam int PW     = 10;
    localparam int DS     = 5;
    localparam int NV     = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_dir = 1'b0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [PER_W-1:0]  cmd_min_per = '0;
    logic              abort = 1'b0;
    logic              cmd_ready, motor_en, motor_dir, motor_step, busy, done;
    logic [STEP_W-1:0] steps_done;

    stepper_move_ctrl #(
        .STEP_W    (STEP_W),
        .PER_W     (PER_W),
        .START_PER (100),
        .ACCEL     (20),
        .PULSE_CYC (PW),
        .DIR_SETUP (DS),
        .HOLD_EN   (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dir     (cmd_dir),
        .cmd_steps   (cmd_steps),
        .cmd_min_per (cmd_min_per),
        .abort       (abort),
        .motor_en    (motor_en),
        .motor_dir   (motor_dir),
        .motor_step  (motor_step),
        .busy        (busy),
        .done        (done),
        .steps_done  (steps_done)
    );

    always #5 clk = ~clk;

    // Edge monitor: cycle index, step rise times, high widths, done/busy counts.
    int   cyc = 0;
    logic prev_step = 1'b0;
    int   last_rise = 0;
    int   rise_q[$];
    int   width_q[$];
    int   done_cnt = 0;
    int   busy_cnt = 0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_step <= motor_step;
        if (motor_step && !prev_step) begin
            rise_q.push_back(cyc + 1);
            last_rise <= cyc + 1;
        end
        if (!motor_step && prev_step) begin
            width_q.push_back(cyc + 1 - last_rise);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    typedef struct {
        logic dir;
        int   steps;
        int   min_per;
        logic ab;
        int   n;
        int   iv_off;
        int   sd;
    } vec_t;

    vec_t tbl[NV];
    int   iv_tab[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic dir, input int steps, input int minp, input logic ab, output int t);
        cmd_dir     = dir;
        cmd_steps   = STEP_W'(steps);
        cmd_min_per = PER_W'(minp);
        abort       = ab;
        cmd_valid   = 1'b1;
        t = cyc;
        chk("cmd_ready_idle", int'(cmd_ready), 1);
        tick;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        chk("cmd_ready_busy", int'(cmd_ready), 0);
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int k = 0; k < 5000; k++) begin
            if (done) begin
                d = cyc;
                break;
            end
            tick;
        end
        if (d < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done pulse within 5000 cycles");
        end
    endtask

    task automatic wait_rises(input int rs, input int target);
        int got;
        got = 0;
        for (int k = 0; k < 5000; k++) begin
            if (rise_q.size() - rs >= target) begin
                got = 1;
                break;
            end
            tick;
        end
        if (got == 0) begin
            checks++;
            failures++;
            $display("FAIL rise_timeout actual=%0d required=%0d", rise_q.size() - rs, target);
        end
    endtask

    task automatic run_row(input int i);
        int rs, ws, b0, dc0, t, d, n;
        rs  = rise_q.size();
        ws  = width_q.size();
        b0  = busy_cnt;
        dc0 = done_cnt;
        $display("move %0d: dir=%0d steps=%0d min_per=%0d abort_at_accept=%0d",
                 i, tbl[i].dir, tbl[i].steps, tbl[i].min_per, tbl[i].ab);
        issue(tbl[i].dir, tbl[i].steps, tbl[i].min_per, tbl[i].ab, t);
        if (tbl[i].steps != 0) begin
            chk("dir_at_T+1", int'(motor_dir), int'(tbl[i].dir));
            chk("en_at_T+1", int'(motor_en), 1);
        end else begin
            chk("en_unchanged_zero_move", int'(motor_en), 0);
            chk("step_zero_move", int'(motor_step), 0);
        end
        wait_done(d);
        n = rise_q.size() - rs;
        chk("rise_count", n, tbl[i].n);
        if (n == tbl[i].n && n > 0) begin
            chk("first_rise_delay", rise_q[rs] - t, 1 + DS);
            chk("done_after_last_pulse", d, rise_q[rs + n - 1] + PW);
            for (int j = 0; j + 1 < n; j++) begin
                chk($sformatf("interval_%0d", j), rise_q[rs + j + 1] - rise_q[rs + j], iv_tab[tbl[i].iv_off + j]);
            end
            chk("width_count", width_q.size() - ws, n);
            if (width_q.size() - ws == n) begin
                for (int j = 0; j < n; j++) begin
                    chk($sformatf("high_width_%0d", j), width_q[ws + j], PW);
                end
            end
        end
        if (tbl[i].steps == 0) chk("zero_move_done_T+1", d - t, 1);
        tick;
        chk("done_one_cycle", int'(done), 0);
        chk("done_pulse_count", done_cnt - dc0, 1);
        chk("busy_cycles", busy_cnt - b0, d - t);
        chk("idle_cmd_ready", int'(cmd_ready), 1);
        chk("idle_motor_en", int'(motor_en), 0);
        chk("idle_step", int'(motor_step), 0);
        chk("steps_done", int'(steps_done), tbl[i].sd);
        for (int k = 0; k < 4; k++) tick;
        chk("steps_done_hold", int'(steps_done), tbl[i].sd);
    endtask

    initial begin
        int rs, t, d, r3, c;

        // Expected rise-to-rise intervals, hand-derived from START=100, ACCEL=20.
        iv_tab.push_back(80); iv_tab.push_back(60); iv_tab.push_back(80); iv_tab.push_back(100);
        iv_tab.push_back(80); iv_tab.push_back(60); iv_tab.push_back(40);
        for (int k = 0; k < 12; k++) iv_tab.push_back(20);
        iv_tab.push_back(40); iv_tab.push_back(60); iv_tab.push_back(80); iv_tab.push_back(100);
        iv_tab.push_back(100); iv_tab.push_back(100);
        iv_tab.push_back(80);

        tbl[0] = '{1'b1, 5,  60,  1'b0, 5,  0,  5};
        tbl[1] = '{1'b0, 1,  60,  1'b0, 1,  0,  1};
        tbl[2] = '{1'b1, 0,  60,  1'b0, 0,  0,  0};
        tbl[3] = '{1'b0, 20, 5,   1'b0, 20, 4,  20};
        tbl[4] = '{1'b1, 3,  200, 1'b1, 3,  23, 3};
        tbl[5] = '{1'b0, 2,  60,  1'b0, 2,  25, 2};

        tick; tick;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(motor_en), 0);
        chk("rst_step", int'(motor_step), 0);
        chk("rst_steps_done", int'(steps_done), 0);
        rst_n = 1'b1;
        tick; tick;

        for (int i = 0; i < NV; i++) run_row(i);

        // Abort during the third high phase: pulse completes, then done.
        $display("seq: abort in 3rd PULSE_HI");
        rs = rise_q.size();
        issue(1'b1, 5, 60, 1'b0, t);
        wait_rises(rs, 3);
        r3 = cyc;
        tick; tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        wait_done(d);
        chk("abort_hi_done_cycle", d, r3 + PW);
        chk("abort_hi_rises", rise_q.size() - rs, 3);
        chk("abort_hi_last_width", width_q[width_q.size() - 1], PW);
        tick;
        chk("abort_hi_steps_done", int'(steps_done), 3);

        // Abort in the low phase: done on the next cycle, no further rise.
        $display("seq: abort in PULSE_LO");
        rs = rise_q.size();
        issue(1'b0, 5, 60, 1'b0, t);
        wait_rises(rs, 2);
        for (int k = 0; k < 15; k++) tick;
        chk("abort_lo_step_low", int'(motor_step), 0);
        abort = 1'b1;
        c = cyc;
        tick;
        abort = 1'b0;
        wait_done(d);
        chk("abort_lo_done_cycle", d, c + 1);
        abort = 1'b1;
        for (int k = 0; k < 100; k++) tick;
        abort = 1'b0;
        chk("abort_lo_no_more_rise", rise_q.size() - rs, 2);
        chk("abort_lo_steps_done", int'(steps_done), 2);
        chk("abort_idle_ignored", int'(busy), 0);

        // Asynchronous reset in the middle of a high phase.
        $display("seq: reset in PULSE_HI");
        rs = rise_q.size();
        issue(1'b1, 5, 60, 1'b0, t);
        wait_rises(rs, 1);
        tick; tick;
        chk("pre_reset_step_high", int'(motor_step), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_step", int'(motor_step), 0);
        chk("async_rst_en", int'(motor_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_cmd_ready", int'(cmd_ready), 1);
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);
        run_row(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
